demux_8b_1x2_buf: RTL and testbench
===================================

// Module: demux_8b_1x2_buf
// PURPOSE
// - Buffered 1-to-2 byte demultiplexer: the reverse direction of the 8-bit 2:1 byte mux.
//   Accepts a byte stream plus a select bit and routes each byte to one of two output
//   streams, each behind its own small FIFO.
// - Sits where one producer feeds two consumers and each consumer stalls on its own;
//   a stalled output blocks only bytes routed to it.
// PARAMETERS
// - WIDTH  8  data width in bits
// - DEPTH  4  entries per output FIFO; power of 2, >= 2
// - AW     2  pointer width, log2(DEPTH); set consistently with DEPTH
// PORTS
// - clk         in   1      rising-edge clock
// - reset       in   1      asynchronous, active-high reset
// - in_data     in   WIDTH  input byte
// - sel         in   1      route select: 0 -> out1, 1 -> out2 (same polarity as the 2:1 mux)
// - in_valid    in   1      in_data/sel valid this cycle
// - in_ready    out  1      selected output FIFO can accept
// - out1_data   out  WIDTH  head byte of FIFO 1
// - out1_valid  out  1      FIFO 1 non-empty
// - out1_ready  in   1      consumer 1 takes the head byte
// - out2_data   out  WIDTH  head byte of FIFO 2
// - out2_valid  out  1      FIFO 2 non-empty
// - out2_ready  in   1      consumer 2 takes the head byte
// - cnt1, cnt2  out  16     bytes delivered on out1/out2 (DEMUX_8B_CNT_EN only)
// - cnt_clr     in   1      synchronous clear of cnt1/cnt2 (DEMUX_8B_CNT_EN only)
// BEHAVIOUR
// - Reset, async: all FIFO pointers and counts -> 0, storage -> 0, out*_valid -> 0,
//   out*_data -> 0, cnt* -> 0. in_ready follows the now-empty FIFOs, so it reads 1.
// - Push: occurs when in_valid && in_ready. in_data is written at the wr_ptr of FIFO[sel].
// - in_ready = !full(FIFO[sel]). It is combinational from sel and the FIFO state only.
//   It has NO combinational path from out*_ready.
// - A full FIFO therefore refuses a push even in a cycle where it also pops.
// - Pop: occurs when outN_valid && outN_ready. rd_ptr advances by 1.
//   outN_ready while outN_valid=0 is ignored.
// - First-word fall-through: outN_data always shows the entry at rd_ptr.
//   A byte pushed into an empty FIFO at edge k drives outN_valid=1 from edge k on,
//   giving 1-cycle latency.
// - Pointers are AW bits and wrap modulo DEPTH.
// - Count is AW+1 bits: +1 on push only, -1 on pop only, unchanged on push+pop.
//   Full is count==DEPTH; empty is count==0.
// - Simultaneous push and pop on the same non-full FIFO: both happen and the count
//   is unchanged.
// - Push to an empty FIFO in the same cycle as a pop attempt: no pop occurs, because
//   valid was 0.
// - The two FIFOs are fully independent. Both may pop in the same cycle while a push
//   goes to either one.
// - Ordering is preserved per output. No ordering is defined across outputs.
// - Reset asserted mid-transfer: all in-flight bytes are discarded. No partial state
//   survives.
// - out*_data while out*_valid=0 is don't-care. The bench must not check it.
// CONFIGURATION
// - DEMUX_8B_CNT_EN defined:
//   - cnt1 and cnt2 are present. Each increments by 1 per pop on its own output and
//     wraps at 16'hFFFF -> 0.
//   - cnt_clr=1 forces both counters to 0 at the next edge. Clear takes priority over
//     an increment in the same cycle.
// - DEMUX_8B_CNT_EN undefined: cnt1, cnt2 and cnt_clr are absent from the port list.
//   All other behaviour is identical.
// TESTING
// - Reset: assert reset mid-cycle -> out1_valid=out2_valid=0 immediately,
//   in_ready=1; cnt*=0 if counters are enabled.
// - Routing: push 8'hA5 with sel=0, then 8'h3C with sel=1, both outN_ready=1 ->
//   out1 shows A5 one cycle after its push and out2 shows 3C one cycle after its push,
//   each valid for 1 cycle.
// - Full/backpressure: out1_ready=0, push 8'h01..8'h04 with sel=0 -> in_ready drops to 0
//   after the 4th push. A sel=1 push of 8'hFF is still accepted and appears on out2.
// - Full + pop same cycle: FIFO1 full, out1_ready=1, in_valid=1, sel=0 -> pop of 8'h01
//   occurs and the push is refused. The next cycle in_ready=1 and the push is accepted.
//   Order out1 = 01,02,03,04,new.
// - Wrap/throughput: stream 8'h00..8'h1F alternating sel, both readies held at 1 ->
//   one push per cycle, no stalls, each output receives its 16 bytes in order;
//   pointers wrap 4 times.
// - DEMUX_8B_CNT_EN: deliver 5 bytes on out1 and 3 on out2 -> cnt1=5, cnt2=3.
//   Pulse cnt_clr together with a pop -> both counters read 0.

Source files
------------

// File: rtl/demux_8b_1x2_buf.sv
// Buffered 1-to-2 byte demultiplexer: each input byte is routed by sel into one of two FWFT FIFOs.
// Optional delivered-byte counters (cnt1/cnt2/cnt_clr) are built when DEMUX_8B_CNT_EN is defined.

module DemuxByteFifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             popReady_i,
   output logic             full_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [AW:0]      count_q, count_d;
   logic             pop;

   // Head entry is always visible, so a freshly written byte is valid right after its edge.
   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign pop     = valid_o && popReady_i;
   assign data_o  = mem_q[rdPtr_q];

   always_comb begin
      wrPtr_d = push_i ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d = pop ? rdPtr_q + 1'b1 : rdPtr_q;
      count_d = count_q;
      if (push_i && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push_i) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         if (push_i) begin
            mem_q[wrPtr_q] <= pushData_i;
         end
      end
   end

endmodule

module demux_8b_1x2_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic             out2_valid,
   input  logic             out2_ready
`ifdef DEMUX_8B_CNT_EN
   ,
   output logic [15:0]      cnt1,
   output logic [15:0]      cnt2,
   input  logic             cnt_clr
`endif
);

   logic full1, full2;
   logic push1, push2;

   // Acceptance looks only at the selected FIFO's fill level, never at the consumers' ready.
   assign in_ready = sel ? !full2 : !full1;
   assign push1    = in_valid && in_ready && !sel;
   assign push2    = in_valid && in_ready && sel;

   DemuxByteFifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) fifo1 (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push1),
      .pushData_i (in_data),
      .popReady_i (out1_ready),
      .full_o     (full1),
      .valid_o    (out1_valid),
      .data_o     (out1_data)
   );

   DemuxByteFifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) fifo2 (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push2),
      .pushData_i (in_data),
      .popReady_i (out2_ready),
      .full_o     (full2),
      .valid_o    (out2_valid),
      .data_o     (out2_data)
   );

`ifdef DEMUX_8B_CNT_EN
   logic [15:0] cnt1_q, cnt2_q;

   // Clear wins over a same-cycle delivery; counters wrap naturally at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else if (cnt_clr) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         if (out1_valid && out1_ready) begin
            cnt1_q <= cnt1_q + 16'd1;
         end
         if (out2_valid && out2_ready) begin
            cnt2_q <= cnt2_q + 16'd1;
         end
      end
   end

   assign cnt1 = cnt1_q;
   assign cnt2 = cnt2_q;
`endif

endmodule

// File: tb/tb_demux_8b_1x2_buf.sv
// Bench for demux_8b_1x2_buf: per-output byte queues model the two FIFOs; a negedge monitor
// pops and compares delivered bytes while the stimulus task records accepted pushes.

module tb_demux_8b_1x2_buf;

   localparam int DEPTH = 4;

   logic       clk;
   logic       reset;
   logic [7:0] in_data;
   logic       sel;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out1_data;
   logic       out1_valid;
   logic       out1_ready;
   logic [7:0] out2_data;
   logic       out2_valid;
   logic       out2_ready;
`ifdef DEMUX_8B_CNT_EN
   logic [15:0] cnt1;
   logic [15:0] cnt2;
   logic        cnt_clr;
   int          modelCnt1;
   int          modelCnt2;
`endif

   int         testsRun;
   int         testsFailed;
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   bit         popped1;
   bit         popped2;

   demux_8b_1x2_buf #(.WIDTH(8), .DEPTH(DEPTH), .AW(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .sel        (sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out2_data  (out2_data),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready)
`ifdef DEMUX_8B_CNT_EN
      ,
      .cnt1       (cnt1),
      .cnt2       (cnt2),
      .cnt_clr    (cnt_clr)
`endif
   );

   // Free-running clock, period 10; rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: at each falling edge compare what each output presents against the model queue
   // head, and retire the head when the consumer is taking it at the coming edge.
   always @(negedge clk) begin
      popped1 = 1'b0;
      popped2 = 1'b0;
      if (!reset) begin
         checkOutput("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
         if (q1.size() != 0) begin
            checkOutput("out1_data", 32'(out1_data), 32'(q1[0]));
            if (out1_ready) begin
               void'(q1.pop_front());
               popped1 = 1'b1;
            end
         end
         checkOutput("out2_valid", 32'(out2_valid), 32'(q2.size() != 0));
         if (q2.size() != 0) begin
            checkOutput("out2_data", 32'(out2_data), 32'(q2[0]));
            if (out2_ready) begin
               void'(q2.pop_front());
               popped2 = 1'b1;
            end
         end
`ifdef DEMUX_8B_CNT_EN
         checkOutput("cnt1", 32'(cnt1), 32'(modelCnt1 % 65536));
         checkOutput("cnt2", 32'(cnt2), 32'(modelCnt2 % 65536));
         if (cnt_clr) begin
            modelCnt1 = 0;
            modelCnt2 = 0;
         end else begin
            if (popped1) modelCnt1++;
            if (popped2) modelCnt2++;
         end
`endif
      end
   end

   // One clock of stimulus. Fill level seen at the edge is the queue size plus anything the
   // monitor just retired for that same edge, so a full FIFO refuses a push even while popping.
   task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d,
                                input logic r1, input logic r2, input logic clr,
                                output logic accepted);
      int fill;
      @(posedge clk);
      #1;
      in_valid   = v;
      sel        = s;
      in_data    = d;
      out1_ready = r1;
      out2_ready = r2;
`ifdef DEMUX_8B_CNT_EN
      cnt_clr    = clr;
`else
      if (clr) begin
         $display("[TB] note: counter clear requested but counters are not built");
      end
`endif
      @(negedge clk);
      #1;
      fill = s ? q2.size() + int'(popped2) : q1.size() + int'(popped1);
      checkOutput("in_ready", 32'(in_ready), 32'(fill < DEPTH));
      accepted = v && (fill < DEPTH);
      if (accepted) begin
         if (s) q2.push_back(d);
         else   q1.push_back(d);
      end
   endtask

   task automatic idleCycles(input int n);
      logic acc;
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, acc);
      end
   endtask

   // Main sequence: reset, directed routing/backpressure cases, streaming, random traffic,
   // reset in the middle of traffic, optional counters, then a bounded drain.
   initial begin
      logic acc;
      int   accCount;
      int   drainCycles;
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b0;
      in_valid    = 1'b0;
      sel         = 1'b0;
      in_data     = 8'h00;
      out1_ready  = 1'b0;
      out2_ready  = 1'b0;
`ifdef DEMUX_8B_CNT_EN
      cnt_clr     = 1'b0;
      modelCnt1   = 0;
      modelCnt2   = 0;
`endif
      #2 reset = 1'b1;
      #1;
      checkOutput("reset_out1_valid", 32'(out1_valid), 32'd0);
      checkOutput("reset_out2_valid", 32'(out2_valid), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef DEMUX_8B_CNT_EN
      checkOutput("reset_cnt1", 32'(cnt1), 32'd0);
      checkOutput("reset_cnt2", 32'(cnt2), 32'd0);
`endif
      #9 reset = 1'b0;

      applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, acc);
      idleCycles(3);

      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, 1'b1, 1'b0, acc);
      end
      applyStimulus(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, acc);
      checkOutput("full_refuses", 32'(acc), 32'd0);
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, acc);
      checkOutput("other_side_accepts", 32'(acc), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, acc);
      checkOutput("full_pop_refuses", 32'(acc), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, acc);
      checkOutput("after_pop_accepts", 32'(acc), 32'd1);
      idleCycles(8);

      accCount = 0;
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 1'(i % 2), 8'(i), 1'b1, 1'b1, 1'b0, acc);
         if (acc) accCount++;
      end
      checkOutput("stream_accepted", 32'(accCount), 32'd32);
      idleCycles(3);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'(($urandom % 4) != 0), 1'($urandom % 2), 8'($urandom),
                       1'(($urandom % 10) < 7), 1'(($urandom % 10) < 6), 1'b0, acc);
      end

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'(i % 2), 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, acc);
      end
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      checkOutput("midreset_out1_valid", 32'(out1_valid), 32'd0);
      checkOutput("midreset_out2_valid", 32'(out2_valid), 32'd0);
      checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
      q1.delete();
      q2.delete();
`ifdef DEMUX_8B_CNT_EN
      modelCnt1 = 0;
      modelCnt2 = 0;
`endif
      @(negedge clk);
      #2 reset = 1'b0;

`ifdef DEMUX_8B_CNT_EN
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), 1'b1, 1'b1, 1'b0, acc);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'(8'h50 + i), 1'b1, 1'b1, 1'b0, acc);
      idleCycles(3);
      checkOutput("cnt1_five", 32'(cnt1), 32'd5);
      checkOutput("cnt2_three", 32'(cnt2), 32'd3);
      applyStimulus(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0, acc);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, acc);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, acc);
      checkOutput("cnt1_cleared", 32'(cnt1), 32'd0);
      checkOutput("cnt2_cleared", 32'(cnt2), 32'd0);
`else
      applyStimulus(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0, acc);
      applyStimulus(1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 1'b0, acc);
`endif

      drainCycles = 0;
      while ((q1.size() != 0 || q2.size() != 0) && drainCycles < 40) begin
         idleCycles(1);
         drainCycles++;
      end
      checkOutput("drain_q1_empty", 32'(q1.size()), 32'd0);
      checkOutput("drain_q2_empty", 32'(q2.size()), 32'd0);
      idleCycles(2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
